antares_branch_predictor: RTL and testbench
===========================================

Name: antares_branch_predictor

Overview:
Parametrised dynamic branch predictor for the Antares fetch stage. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and a return address stack (RAS). It predicts taken/target for the IF-stage PC and carries that prediction into ID. When the ID-stage branch unit resolves the branch, the block compares the resolution against the carried prediction, flags a mispredict, and trains its tables.

Parameters:
BTB_INDEX_BITS, 4, log2 of BTB entries (default 16 entries); index = pc[BTB_INDEX_BITS+1:2]
RAS_PTR_BITS, 2, log2 of RAS depth (default 4 entries)
COUNTER_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
if_pc  in  32  PC of the instruction being fetched
if_stall  in  1  IF/ID hold; when high, the carried prediction is held
if_flush  in  1  IF/ID flush; clears the carried prediction
if_predict_taken  out  1  prediction for if_pc (combinational from stored state)
if_predict_target  out  32  predicted target for if_pc
id_update_valid  in  1  ID has resolved a control-flow instruction this cycle
id_update_pc  in  32  PC of the resolved instruction
id_update_taken  in  1  actual direction (id_take_branch)
id_update_target  in  32  actual target (pc_branch_address)
id_update_uncond  in  1  J/JAL/JR/JALR
id_update_call  in  1  JAL/JALR/BGEZAL/BLTZAL, taken
id_update_return  in  1  JR with rs = $31
id_mispredict  out  1  registered-prediction mismatch, valid only when id_update_valid
id_pred_taken  out  1  prediction carried into ID (debug/verification)
id_pred_target  out  32  target carried into ID

Behaviour:
- Reset (async):
  - All BTB valid bits cleared; counters set to 00.
  - RAS pointer and count set to 0.
  - id_pred_taken = 0, id_pred_target = 0.
  - Consequence: if_predict_taken = 0 and id_mispredict = 0 until the first update.
- BTB entry fields: valid, tag = pc[31:BTB_INDEX_BITS+2], target[31:0], ctr[1:0], is_return.
- Lookup (IF, zero latency):
  - hit = valid & tag match.
  - Non-return hit: taken = ctr[1]; target = stored target.
  - Return hit: taken = (ras_count != 0); target = RAS top.
  - Miss: taken = 0; target = if_pc + 4.
- Carried prediction (IF/ID register), at each posedge:
  - if_flush: cleared to 0/0. if_flush has priority over if_stall.
  - else if_stall: held.
  - else: loaded with if_predict_taken/if_predict_target.
- Mispredict (combinational on id_update_*):
  - id_mispredict = id_update_valid & ((id_update_taken != id_pred_taken) | (id_update_taken & id_update_target != id_pred_target)).
- Training, at posedge when id_update_valid:
  - Hit, conditional branch: ctr increments on taken and decrements on not-taken, saturating at 11 and 00. Target is overwritten when taken.
  - Hit, uncond: ctr = 11; target overwritten.
  - Miss and taken: allocate, overwriting the entry unconditionally (direct-mapped). Fields written: valid = 1, tag, target, is_return = id_update_return. ctr = 11 if uncond, else COUNTER_INIT.
  - Miss and not-taken: no allocation.
- RAS, at posedge when id_update_valid:
  - call: push id_update_pc + 8 (return address past the delay slot).
    - Pointer wraps modulo 2^RAS_PTR_BITS.
    - Count saturates at depth; on overflow the oldest entry is overwritten.
  - return: pop; count decrements and saturates at 0. Pop on empty changes nothing.
  - call and return never both high; if they are, call wins.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents; the new contents are visible next cycle.
- Reset asserted mid-operation: all state clears immediately; no partial update survives.
- Widths: all PC arithmetic is 32-bit unsigned modulo 2^32. The tag width adapts to BTB_INDEX_BITS.

Decomposition:
- antares_defines.v gains the counter encodings:
  - CTR_SNT = 2'b00
  - CTR_WNT = 2'b01
  - CTR_WT = 2'b10
  - CTR_ST = 2'b11
- The existing OP_/RT_OP_/FUNCTION_OP_ macros are reused by the ID decoder that drives the update_* qualifiers. They are not used inside this block.
- One sub-module: antares_return_stack, which holds the RAS storage, pointer and count, and provides push/pop/top/empty.

Test Plan:
1. Reset, then if_pc = 0x00400010 -> if_predict_taken = 0, target = 0x00400014, id_pred_* = 0.
2. Update pc = 0x00400010, taken, target 0x00400100, conditional -> next cycle lookup of 0x00400010 gives taken = 1, target 0x00400100, ctr = 10. Two not-taken updates -> ctr = 00, predicts not-taken; third not-taken stays 00.
3. Alias: 0x00400010 and 0x00400050 share index 4 with default BTB_INDEX_BITS. Allocate the second -> lookup of 0x00400010 misses (predicts 0x00400014).
4. Call at 0x00400200 (push 0x00400208), then allocate return JR at 0x00400300 -> lookup of 0x00400300 gives taken = 1, target 0x00400208. Five calls with depth 4 -> the first push is lost; four pops then give RAS empty and the return predicts not-taken.
5. Predict taken 0x00400100 and carry into ID; update taken with target 0x00400180 -> id_mispredict = 1. Same case with if_stall high for 2 cycles -> id_pred_* held. if_flush -> id_pred_taken = 0.
6. Assert rst asynchronously between clock edges during a pending update -> all outputs go to reset values immediately and the BTB entry is not written.

Source files
------------

// File: rtl/antares_branch_predictor_pkg.sv
// antares_branch_predictor_pkg: 2-bit counter encodings and saturating update shared by the predictor
package antares_branch_predictor_pkg;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    return taken ? (ctr == CTR_ST ? CTR_ST : ctr + 2'd1) : (ctr == CTR_SNT ? CTR_SNT : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/antares_return_stack.sv
// antares_return_stack: circular return address stack whose oldest entry is overwritten on overflow
module antares_return_stack #(
  parameter int PTR_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_addr,
  output logic [31:0] top,
  output logic        empty
);
  localparam int DEPTH = 1 << PTR_BITS;
  logic [31:0]         stack [DEPTH];
  logic [PTR_BITS-1:0] ptr;
  logic [PTR_BITS-1:0] top_ptr;
  logic [PTR_BITS:0]   count;

  assign top_ptr = ptr - 1'b1;
  assign top     = stack[top_ptr];
  assign empty   = count == '0;

  always_ff @(posedge clk)
    if (push) stack[ptr] <= push_addr;

  // count's MSB set means the stack is full, so it stops growing there
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (!count[PTR_BITS]) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= top_ptr;
      count <= count - 1'b1;
    end
endmodule

// File: rtl/antares_branch_predictor.sv
// antares_branch_predictor: direct-mapped BTB with 2-bit counters plus a RAS, predicting in IF and checking in ID
module antares_branch_predictor
  import antares_branch_predictor_pkg::*;
#(
  parameter int         BTB_INDEX_BITS = 4,
  parameter int         RAS_PTR_BITS   = 2,
  parameter logic [1:0] COUNTER_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_stall,
  input  logic        if_flush,
  output logic        if_predict_taken,
  output logic [31:0] if_predict_target,
  input  logic        id_update_valid,
  input  logic [31:0] id_update_pc,
  input  logic        id_update_taken,
  input  logic [31:0] id_update_target,
  input  logic        id_update_uncond,
  input  logic        id_update_call,
  input  logic        id_update_return,
  output logic        id_mispredict,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_target
);
  localparam int ENTRIES  = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS = 30 - BTB_INDEX_BITS;

  logic                btb_valid  [ENTRIES];
  logic                btb_ret    [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic [1:0]          btb_ctr    [ENTRIES];

  logic [BTB_INDEX_BITS-1:0] if_idx, u_idx;
  logic [TAG_BITS-1:0]       if_tag, u_tag;
  logic                      if_hit, u_hit, ras_empty;
  logic [31:0]               ras_top;

  assign if_idx = if_pc[BTB_INDEX_BITS+1:2];
  assign if_tag = if_pc[31:BTB_INDEX_BITS+2];
  assign u_idx  = id_update_pc[BTB_INDEX_BITS+1:2];
  assign u_tag  = id_update_pc[31:BTB_INDEX_BITS+2];
  assign if_hit = btb_valid[if_idx] && btb_tag[if_idx] == if_tag;
  assign u_hit  = btb_valid[u_idx] && btb_tag[u_idx] == u_tag;

  always_comb begin
    if_predict_taken  = !if_hit ? 1'b0 : btb_ret[if_idx] ? !ras_empty : btb_ctr[if_idx][1];
    if_predict_target = !if_hit ? if_pc + 32'd4 : btb_ret[if_idx] ? ras_top : btb_target[if_idx];
  end

  assign id_mispredict = id_update_valid &&
    ((id_update_taken != id_pred_taken) || (id_update_taken && id_update_target != id_pred_target));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (if_flush) begin
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (!if_stall) begin
      id_pred_taken  <= if_predict_taken;
      id_pred_target <= if_predict_target;
    end

  // a taken miss evicts whatever shares the index; a not-taken miss leaves the table alone
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_ret[i]    <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= CTR_SNT;
      end
    end else if (id_update_valid) begin
      if (u_hit) begin
        btb_ctr[u_idx] <= id_update_uncond ? CTR_ST : ctr_next(btb_ctr[u_idx], id_update_taken);
        if (id_update_taken || id_update_uncond) btb_target[u_idx] <= id_update_target;
      end else if (id_update_taken) begin
        btb_valid[u_idx]  <= 1'b1;
        btb_tag[u_idx]    <= u_tag;
        btb_target[u_idx] <= id_update_target;
        btb_ret[u_idx]    <= id_update_return;
        btb_ctr[u_idx]    <= id_update_uncond ? CTR_ST : COUNTER_INIT;
      end
    end

  antares_return_stack #(.PTR_BITS(RAS_PTR_BITS)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (id_update_valid && id_update_call),
    .pop       (id_update_valid && id_update_return && !id_update_call),
    .push_addr (id_update_pc + 32'd8),
    .top       (ras_top),
    .empty     (ras_empty)
  );
endmodule

// File: tb/tb_antares_branch_predictor.sv
// tb_antares_branch_predictor: table-driven vectors for BTB/IF-ID behaviour plus directed RAS and async-reset sequences
module tb_antares_branch_predictor;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_stall = 1'b0, if_flush = 1'b0;
  logic        if_predict_taken;
  logic [31:0] if_predict_target;
  logic        id_update_valid = 1'b0;
  logic [31:0] id_update_pc = '0, id_update_target = '0;
  logic        id_update_taken = 1'b0, id_update_uncond = 1'b0, id_update_call = 1'b0, id_update_return = 1'b0;
  logic        id_mispredict, id_pred_taken;
  logic [31:0] id_pred_target;

  antares_branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_stall(if_stall), .if_flush(if_flush),
    .if_predict_taken(if_predict_taken), .if_predict_target(if_predict_target),
    .id_update_valid(id_update_valid), .id_update_pc(id_update_pc), .id_update_taken(id_update_taken),
    .id_update_target(id_update_target), .id_update_uncond(id_update_uncond), .id_update_call(id_update_call),
    .id_update_return(id_update_return), .id_mispredict(id_mispredict),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        stall, flush, uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uu;
    logic        et;
    logic [31:0] etgt;
    logic        ept;
    logic [31:0] eptgt;
    logic        emis;
  } vec_t;

  localparam logic [31:0] A = 32'h0040_0010, A4 = 32'h0040_0014, B = 32'h0040_0050;
  localparam logic [31:0] T1 = 32'h0040_0100, T5 = 32'h0040_0500, T58 = 32'h0040_0580, T6 = 32'h0040_0600;
  localparam logic [31:0] RET_PC = 32'h0040_0304;

  vec_t vt[22];
  int   applied = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_update();
    id_update_valid = 1'b0; id_update_pc = '0; id_update_taken = 1'b0; id_update_target = '0;
    id_update_uncond = 1'b0; id_update_call = 1'b0; id_update_return = 1'b0;
  endtask

  task automatic apply(input int n, input vec_t v);
    @(negedge clk);
    if_pc = v.pc; if_stall = v.stall; if_flush = v.flush;
    clear_update();
    id_update_valid = v.uv; id_update_pc = v.upc; id_update_taken = v.ut;
    id_update_target = v.utgt; id_update_uncond = v.uu;
    #1;
    check($sformatf("v%0d if_predict_taken", n), {31'd0, if_predict_taken}, {31'd0, v.et});
    check($sformatf("v%0d if_predict_target", n), if_predict_target, v.etgt);
    check($sformatf("v%0d id_pred_taken", n), {31'd0, id_pred_taken}, {31'd0, v.ept});
    check($sformatf("v%0d id_pred_target", n), id_pred_target, v.eptgt);
    check($sformatf("v%0d id_mispredict", n), {31'd0, id_mispredict}, {31'd0, v.emis});
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic unc, input logic call, input logic ret);
    @(negedge clk);
    id_update_valid = 1'b1; id_update_pc = pc; id_update_taken = 1'b1; id_update_target = tgt;
    id_update_uncond = unc; id_update_call = call; id_update_return = ret;
    @(posedge clk);
    #1 clear_update();
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic et, input logic [31:0] etgt, input logic chk_tgt);
    @(negedge clk);
    if_pc = pc;
    #1;
    check({name, " taken"}, {31'd0, if_predict_taken}, {31'd0, et});
    if (chk_tgt) check({name, " target"}, if_predict_target, etgt);
  endtask

  initial begin
    logic [31:0] call_pc [5];
    vt[0]  = '{A, 0, 0, 0, 0, 0, 0,   0, 0, A4,  0, A4,  0};
    vt[1]  = '{A, 0, 0, 1, A, 1, T1,  0, 0, A4,  0, A4,  1};
    vt[2]  = '{A, 0, 0, 1, A, 0, 0,   0, 1, T1,  0, A4,  0};
    vt[3]  = '{A, 0, 0, 1, A, 0, 0,   0, 0, T1,  1, T1,  1};
    vt[4]  = '{A, 0, 0, 1, A, 0, 0,   0, 0, T1,  0, T1,  0};
    vt[5]  = '{A, 0, 0, 1, A, 1, T1,  0, 0, T1,  0, T1,  1};
    vt[6]  = '{A, 0, 0, 0, 0, 0, 0,   0, 0, T1,  0, T1,  0};
    vt[7]  = '{A, 0, 0, 1, B, 1, T5,  0, 0, T1,  0, T1,  1};
    vt[8]  = '{A, 0, 0, 0, 0, 0, 0,   0, 0, A4,  0, T1,  0};
    vt[9]  = '{B, 0, 0, 0, 0, 0, 0,   0, 1, T5,  0, A4,  0};
    vt[10] = '{B, 0, 0, 1, B, 1, T5,  0, 1, T5,  1, T5,  0};
    vt[11] = '{B, 0, 0, 1, B, 1, T58, 0, 1, T5,  1, T5,  1};
    vt[12] = '{A, 1, 0, 0, 0, 0, 0,   0, 0, A4,  1, T5,  0};
    vt[13] = '{A, 1, 0, 0, 0, 0, 0,   0, 0, A4,  1, T5,  0};
    vt[14] = '{B, 0, 0, 0, 0, 0, 0,   0, 1, T58, 1, T5,  0};
    vt[15] = '{B, 1, 1, 0, 0, 0, 0,   0, 1, T58, 1, T58, 0};
    vt[16] = '{A, 0, 0, 0, 0, 0, 0,   0, 0, A4,  0, 0,   0};
    vt[17] = '{B, 0, 0, 1, B, 0, 0,   0, 1, T58, 0, A4,  0};
    vt[18] = '{B, 0, 0, 1, B, 0, 0,   0, 1, T58, 1, T58, 1};
    vt[19] = '{B, 0, 0, 0, 0, 0, 0,   0, 0, T58, 1, T58, 0};
    vt[20] = '{B, 0, 0, 1, B, 1, T6,  1, 0, T58, 0, T58, 1};
    vt[21] = '{B, 0, 0, 0, 0, 0, 0,   0, 1, T6,  0, T58, 0};
    call_pc = '{32'h0040_0208, 32'h0040_020C, 32'h0040_0218, 32'h0040_021C, 32'h0040_0220};

    if_pc = A;
    #12;
    check("reset if_predict_taken", {31'd0, if_predict_taken}, 32'd0);
    check("reset if_predict_target", if_predict_target, A4);
    check("reset id_pred_taken", {31'd0, id_pred_taken}, 32'd0);
    check("reset id_pred_target", id_pred_target, 32'd0);
    check("reset id_mispredict", {31'd0, id_mispredict}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 22; i++) apply(i, vt[i]);
    @(negedge clk);
    if_stall = 1'b0; if_flush = 1'b0;
    clear_update();

    upd(RET_PC, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    look("ret empty", RET_PC, 1'b0, '0, 1'b0);
    upd(32'h0040_0200, 32'h0040_1000, 1'b1, 1'b1, 1'b0);
    look("ret after call", RET_PC, 1'b1, 32'h0040_0208, 1'b1);
    upd(RET_PC, 32'h0040_0208, 1'b1, 1'b0, 1'b1);
    look("ret after pop", RET_PC, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) upd(call_pc[i], 32'h0040_1000, 1'b1, 1'b1, 1'b0);
    look("ras top 5 calls", RET_PC, 1'b1, 32'h0040_0228, 1'b1);
    upd(RET_PC, 32'h0, 1'b1, 1'b0, 1'b1);
    look("ras pop1", RET_PC, 1'b1, 32'h0040_0224, 1'b1);
    upd(RET_PC, 32'h0, 1'b1, 1'b0, 1'b1);
    look("ras pop2", RET_PC, 1'b1, 32'h0040_0220, 1'b1);
    upd(RET_PC, 32'h0, 1'b1, 1'b0, 1'b1);
    look("ras pop3 oldest lost", RET_PC, 1'b1, 32'h0040_0214, 1'b1);
    upd(RET_PC, 32'h0, 1'b1, 1'b0, 1'b1);
    look("ras pop4 empty", RET_PC, 1'b0, '0, 1'b0);

    look("pre-reset lookup", B, 1'b1, T6, 1'b1);
    @(negedge clk);
    id_update_valid = 1'b1; id_update_pc = 32'h0040_0040; id_update_taken = 1'b1; id_update_target = 32'h0040_0700;
    #1;
    check("pre-reset id_pred_taken", {31'd0, id_pred_taken}, 32'd1);
    check("pre-reset id_pred_target", id_pred_target, T6);
    #2 rst = 1'b1;
    #1;
    check("async rst id_pred_taken", {31'd0, id_pred_taken}, 32'd0);
    check("async rst id_pred_target", id_pred_target, 32'd0);
    check("async rst if_predict_taken", {31'd0, if_predict_taken}, 32'd0);
    check("async rst if_predict_target", if_predict_target, 32'h0040_0054);
    @(posedge clk);
    @(negedge clk);
    clear_update();
    rst = 1'b0;
    look("no write under rst", 32'h0040_0040, 1'b0, 32'h0040_0044, 1'b1);
    look("btb cleared", B, 1'b0, 32'h0040_0054, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
